// File: rtl/arm_pkg.sv
// Shared architectural definitions for the status/flag logic:
// condition codes, NZCV bit positions and the status word type.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    // Reserved encoding; treated like any other flag-dependent condition.
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] status_t;

    // Only "always" skips the flag check; everything else, including the
    // reserved code, must wait for final flags.
    function automatic logic cond_needs_flags(input logic valid, input logic [3:0] cond);
        return valid & (cond != COND_AL);
    endfunction

endpackage

// File: rtl/flag_pending_counter.sv
// Up/down counter of in-flight flag-setting instructions.
// Flush clears the count outright; overflow past MAX_PENDING and
// underflow below zero both hold the count and set a sticky error.
module flag_pending_counter #(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next count: flush dominates, simultaneous inc/dec cancel, saturate at both ends.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) err_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    // Count and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/status_flag_unit.sv
// NZCV status register with in-flight flag-setter tracking and the
// ID-stage flag hazard. Optional macro STATUS_BYPASS_EN forwards the
// value being written this cycle onto status_bits and lets a waiting
// conditional instruction proceed in the commit cycle itself.
module status_flag_unit
    import arm_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_s,
    input  logic             id_issue,
    input  logic             exe_s_commit,
    input  logic [3:0]       exe_flags,
    input  logic             msr_we,
    input  logic [3:0]       msr_data,
    input  logic             flush,
    output logic [3:0]       status_bits,
    output logic             flag_hazard,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             pend_err
);

    status_t status_q, status_d;
    logic    needs_flags;
    logic    inc, dec;

    assign needs_flags = cond_needs_flags(id_valid, id_cond);
    assign dec         = exe_s_commit;
    // A stalled setter is not counted; only instructions actually leaving ID are.
    assign inc         = id_issue & id_s & ~flag_hazard;

    // Register write priority: direct MSR write beats the EXE commit.
    // Flush does not block either, since the commit is older than the flush.
    always_comb begin
        status_d = status_q;
        if (msr_we)            status_d = msr_data;
        else if (exe_s_commit) status_d = exe_flags;
    end

    // Architectural NZCV register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_q <= '0;
        else        status_q <= status_d;
    end

    flag_pending_counter #(
        .MAX_PENDING (MAX_PENDING),
        .CNT_W       (CNT_W)
    ) u_pending (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .inc_i   (inc),
        .dec_i   (dec),
        .cnt_o   (pending_cnt),
        .err_o   (pend_err)
    );

`ifdef STATUS_BYPASS_EN
    assign status_bits = status_d;
    assign flag_hazard = needs_flags & ((pending_cnt - CNT_W'(dec)) != '0);
`else
    assign status_bits = status_q;
    assign flag_hazard = needs_flags & (pending_cnt != '0);
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit. Each cycle the stimulus is applied
// after the falling edge, the expected snapshot
// {status_bits, flag_hazard, pending_cnt, pend_err} is queued, and it is
// popped and compared shortly afterwards, before the next rising edge.
module tb_status_flag_unit;
    import arm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_s;
    logic       id_issue;
    logic       exe_s_commit;
    logic [3:0] exe_flags;
    logic       msr_we;
    logic [3:0] msr_data;
    logic       flush;
    logic [3:0] status_bits;
    logic       flag_hazard;
    logic [2:0] pending_cnt;
    logic       pend_err;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int total = 0;
    int bad   = 0;

    status_flag_unit #(.MAX_PENDING(3), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_cond      (id_cond),
        .id_s         (id_s),
        .id_issue     (id_issue),
        .exe_s_commit (exe_s_commit),
        .exe_flags    (exe_flags),
        .msr_we       (msr_we),
        .msr_data     (msr_data),
        .flush        (flush),
        .status_bits  (status_bits),
        .flag_hazard  (flag_hazard),
        .pending_cnt  (pending_cnt),
        .pend_err     (pend_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Picks the expectation that applies to the build under test.
    function automatic logic [3:0] sel4(input logic [3:0] reg_v, input logic [3:0] byp_v);
`ifdef STATUS_BYPASS_EN
        return byp_v;
`else
        return reg_v;
`endif
    endfunction

    task automatic idle();
        id_valid = 0; id_cond = COND_AL; id_s = 0; id_issue = 0;
        exe_s_commit = 0; exe_flags = 4'h0; msr_we = 0; msr_data = 4'h0; flush = 0;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] s, input logic h,
                            input logic [2:0] c, input logic e);
        sb_item_t it;
        it.tag = tag;
        it.exp = {s, h, c, e};
        sb.push_back(it);
    endtask

    task automatic pop_cmp();
        sb_item_t   it;
        logic [8:0] obs;
        it  = sb.pop_front();
        obs = {status_bits, flag_hazard, pending_cnt, pend_err};
        total++;
        assert (obs === it.exp) else begin
            bad++;
            $error("FAIL %s observed={s=%b h=%b c=%0d e=%b} expected={s=%b h=%b c=%0d e=%b}",
                   it.tag, obs[8:5], obs[4], obs[3:1], obs[0],
                   it.exp[8:5], it.exp[4], it.exp[3:1], it.exp[0]);
        end
    endtask

    // Inputs are already applied (we sit just after a falling edge).
    task automatic cyc(input string tag, input logic [3:0] s, input logic h,
                       input logic [2:0] c, input logic e);
        push_exp(tag, s, h, c, e);
        #1;
        pop_cmp();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setter_al();
        idle();
        id_valid = 1; id_cond = COND_AL; id_s = 1; id_issue = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        idle();
        cyc("reset_state", 4'b0000, 0, 0, 0);

        // Setter issues with AL condition; it does not need flags itself.
        setter_al();
        cyc("setter_issue", 4'b0000, 0, 0, 0);
        // Conditional waits while the setter commits.
        idle(); id_valid = 1; id_cond = COND_EQ; exe_s_commit = 1; exe_flags = 4'b0100;
`ifdef STATUS_BYPASS_EN
        cyc("hazard_commit_cycle", 4'b0100, 0, 1, 0);
`else
        cyc("hazard_commit_cycle", 4'b0000, 1, 1, 0);
`endif
        idle(); id_valid = 1; id_cond = COND_EQ; id_issue = 1;
        cyc("hazard_released", 4'b0100, 0, 0, 0);

        // Build count to 2, then AL and reserved conditions.
        setter_al();
        cyc("fill_0", 4'b0100, 0, 0, 0);
        setter_al();
        cyc("fill_1", 4'b0100, 0, 1, 0);
        idle(); id_valid = 1; id_cond = COND_AL; id_issue = 1;
        cyc("al_no_hazard", 4'b0100, 0, 2, 0);
        // Reserved cond stalls; the stalled setter must not be counted.
        idle(); id_valid = 1; id_cond = COND_NV; id_s = 1; id_issue = 1;
        cyc("reserved_cond_hazard", 4'b0100, 1, 2, 0);

        // Commit one setter, then MSR write collides with a commit.
        idle(); exe_s_commit = 1; exe_flags = 4'b0110;
        cyc("stalled_setter_not_counted", sel4(4'b0100, 4'b0110), 0, 2, 0);
        idle(); msr_we = 1; msr_data = 4'b0011; exe_s_commit = 1; exe_flags = 4'b1100;
        cyc("priority_cycle", sel4(4'b0110, 4'b0011), 0, 1, 0);
        idle();
        cyc("priority_msr_wins", 4'b0011, 0, 0, 0);

        // Flush with a same-cycle commit and a same-cycle issue.
        setter_al();
        cyc("flush_fill_0", 4'b0011, 0, 0, 0);
        setter_al();
        cyc("flush_fill_1", 4'b0011, 0, 1, 0);
        setter_al(); flush = 1; exe_s_commit = 1; exe_flags = 4'b1000;
        cyc("flush_cycle", sel4(4'b0011, 4'b1000), 0, 2, 0);
        idle(); id_valid = 1; id_cond = COND_NE;
        cyc("flush_result", 4'b1000, 0, 0, 0);

        // Saturation: four setters against MAX_PENDING=3.
        setter_al();
        cyc("sat_0", 4'b1000, 0, 0, 0);
        setter_al();
        cyc("sat_1", 4'b1000, 0, 1, 0);
        setter_al();
        cyc("sat_2", 4'b1000, 0, 2, 0);
        setter_al();
        cyc("sat_3", 4'b1000, 0, 3, 0);
        idle();
        cyc("sat_hold_err", 4'b1000, 0, 3, 1);

        // Set register to 1010 and count to 2, then reset mid-cycle.
        idle(); msr_we = 1; msr_data = 4'b1010; exe_s_commit = 1; exe_flags = 4'b0000;
        cyc("pre_reset_write", sel4(4'b1000, 4'b1010), 0, 3, 1);
        idle();
        push_exp("pre_reset_state", 4'b1010, 0, 2, 1);
        #1;
        pop_cmp();
        #2;
        rst_n = 0;
        push_exp("async_reset", 4'b0000, 0, 0, 0);
        #1;
        pop_cmp();
        @(negedge clk);
        push_exp("reset_held_over_edge", 4'b0000, 0, 0, 0);
        #1;
        pop_cmp();
        rst_n = 1;
        @(negedge clk);

        // Underflow: commit with nothing pending.
        idle(); exe_s_commit = 1; exe_flags = 4'b0101;
        cyc("underflow_cycle", sel4(4'b0000, 4'b0101), 0, 0, 0);
        idle();
        cyc("underflow_err", 4'b0101, 0, 0, 1);
        idle(); id_valid = 1; id_cond = COND_MI;
        cyc("err_sticky", 4'b0101, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Holds the architectural NZCV status register and drives the 4-bit status bus {N,Z,C,V} that feeds the condition-check stage.
- Tracks in-flight flag-setting instructions between issue (ID) and flag commit (EXE).
- Raises a flag hazard so a conditional instruction in ID stalls until its flags are final.
- Provides a privileged direct-write port for MSR-style updates and a pipeline-flush input.

Parameters:
- MAX_PENDING, 3, maximum in-flight flag-setting instructions tracked (1..7).
- CNT_W, 3, width of the pending counter; must satisfy 2^CNT_W > MAX_PENDING.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID stage holds a valid instruction this cycle.
- id_cond  input  4  condition field of the ID instruction.
- id_s  input  1  ID instruction sets flags; counted on issue.
- id_issue  input  1  ID instruction advances to EXE this cycle (not stalled).
- exe_s_commit  input  1  EXE flag-setting instruction writes its flags this cycle.
- exe_flags  input  4  ALU result flags {N,Z,C,V}.
- msr_we  input  1  direct status write.
- msr_data  input  4  direct write value.
- flush  input  1  squash all in-flight instructions.
- status_bits  output  4  {N,Z,C,V} to condition check.
- flag_hazard  output  1  stall request for ID.
- pending_cnt  output  CNT_W  in-flight flag-setter count.
- pend_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): NZCV register=0, pending_cnt=0, pend_err=0. Consequently status_bits=4'b0000 and flag_hazard=0.
- Register update priority per rising edge: msr_we, then exe_s_commit, then hold.
  - msr_we writes msr_data.
  - exe_s_commit writes exe_flags.
  - msr_we=1 with exe_s_commit=1 in the same cycle: msr_data wins, and the commit still decrements the counter.
- Flag needs:
  - needs_flags = id_valid & (id_cond != 4'b1110).
  - 4'b1111 is reserved and is treated as needing flags.
- flag_hazard = needs_flags & (pending_cnt != 0). It is combinational and has no bubble after the count reaches 0.
- Issue counting: inc = id_issue & id_s & ~flag_hazard. dec = exe_s_commit.
- Counter update per edge:
  - flush=1: pending_cnt becomes 0 and inc/dec are ignored. The register still accepts msr_we and exe_s_commit that cycle, because the EXE commit is architecturally older than the flush.
  - inc & dec: count unchanged.
  - inc only: +1. If the count is already MAX_PENDING, it holds and pend_err is set.
  - dec only: −1. If the count is already 0, it holds at 0 and pend_err is set.
- pend_err is sticky until reset.
- Latency: a committed flag is visible on status_bits the cycle after exe_s_commit (without the bypass feature).
- A conditional instruction waiting on a setter stalls until the cycle after the setter's commit, when the count reads 0.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Optional Feature:
- Macro STATUS_BYPASS_EN.
- Defined:
  - status_bits becomes combinational: msr_we ? msr_data : exe_s_commit ? exe_flags : register.
  - flag_hazard = needs_flags & (pending_cnt − dec != 0), so a waiting ID instruction proceeds in the commit cycle itself.
- Undefined: status_bits = register only, and behaviour is as above.

Decomposition:
- Shared package (arm_pkg):
  - condition-code localparams (COND_EQ=4'b0000 … COND_AL=4'b1110).
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0).
  - typedef status_t (4-bit).
- One natural sub-module: flag_pending_counter, an up/down counter with flush, saturation and sticky error, parameterised by MAX_PENDING and CNT_W.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle with the register at 4'b1010 and the count at 2.
  - Required: status_bits=0, pending_cnt=0 and pend_err=0 immediately.
- Hazard and commit:
  - Stimulus: issue a setter (id_s=1, id_issue=1); next cycle ID has cond=4'b0000; commit exe_flags=4'b0100 one cycle later.
  - Required: flag_hazard=1 for exactly one cycle; on the following cycle status_bits=4'b0100 and flag_hazard=0.
- AL instruction: cond=4'b1110 while the count is 2 → flag_hazard=0.
- Write priority:
  - Stimulus: msr_we=1 with msr_data=4'b0011, simultaneously exe_s_commit=1 with exe_flags=4'b1100, count=1.
  - Required: status_bits=4'b0011 next cycle, pending_cnt=0.
- Saturation and underflow:
  - Issue 4 setters with MAX_PENDING=3 → count holds at 3 and pend_err=1.
  - After reset, commit at count 0 → count stays 0 and pend_err=1.
- Flush:
  - Stimulus: count=2, then flush=1 together with exe_s_commit=1 and exe_flags=4'b1000.
  - Required: pending_cnt=0 and status_bits=4'b1000.
  - With STATUS_BYPASS_EN defined: the hazard clears during the commit cycle itself.
